// File: rtl/r2r_sar_adc_multich_if.sv
// Signal bundle between the multi-channel SAR ADC core and its analog front end / result consumer.
// Latency: none (wires only).
// Backpressure: none; result_valid is a one-cycle pulse with no ready path.
interface r2r_sar_adc_multich_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // control and analog inputs to the converter
  logic                compare_match_n;
  logic                mode;
  logic                start;
  logic [CHANNELS-1:0] channel_mask;

  // front-end drive and result outputs from the converter
  logic                sample_control;
  logic [CH_W-1:0]     channel_sel;
  logic [WIDTH-1:0]    r2r_out;
  logic                busy;
  logic [WIDTH-1:0]    result;
  logic [CH_W-1:0]     result_channel;
  logic                result_valid;
  logic                overrun;

  // converter side
  modport master (
    input  compare_match_n,
    input  mode,
    input  start,
    input  channel_mask,
    output sample_control,
    output channel_sel,
    output r2r_out,
    output busy,
    output result,
    output result_channel,
    output result_valid,
    output overrun
  );

  // front end / consumer side
  modport slave (
    output compare_match_n,
    output mode,
    output start,
    output channel_mask,
    input  sample_control,
    input  channel_sel,
    input  r2r_out,
    input  busy,
    input  result,
    input  result_channel,
    input  result_valid,
    input  overrun
  );
endinterface

// File: rtl/r2r_sar_adc_multich.sv
// Multi-channel R2R successive-approximation ADC controller with round-robin scan and rate divider.
// Latency: trigger edge t -> result_valid in cycle t + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1.
// Backpressure: none; triggers while busy are dropped (continuous-mode strobes flag sticky overrun).
module r2r_sar_adc_multich #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int DIV           = 100_000,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  r2r_sar_adc_multich_if.master adc
);

  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W   = $clog2(DIV);
  localparam int BIT_W   = $clog2(WIDTH);
  localparam int TIM_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int TIM_W   = $clog2(TIM_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [TIM_W-1:0] SAMPLE_LAST = TIM_W'(SAMPLE_CYCLES - 1);
  localparam logic [TIM_W-1:0] SETTLE_LAST = TIM_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MSB     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRIAL_MSB   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CH_W-1:0]  PTR_RESET   = CH_W'(CHANNELS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  logic [2:0]       state;
  logic [TIM_W-1:0] timer;
  logic [BIT_W-1:0] bit_idx;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] trial_kept;
  logic [WIDTH-1:0] trial_next;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  ch_sel;
  logic [CH_W-1:0]  next_ch;
  logic [CH_W-1:0]  hi_ch;
  logic [CH_W-1:0]  lo_ch;
  logic             hi_found;
  logic [WIDTH-1:0] res;
  logic [CH_W-1:0]  res_ch;
  logic             res_vld;
  logic             ovr;
  logic             any_enabled;
  logic             trigger;

  // Conversion-rate divider: free-running 0..DIV-1 in both modes, strobe on the last count.
  assign strobe = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Round-robin pick: lowest enabled channel above the pointer, else wrap to lowest enabled overall.
  // Descending scan so the final write in each category is the lowest qualifying index.
  always_comb begin
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (adc.channel_mask[c]) begin
        lo_ch = CH_W'(c);
        if (CH_W'(c) > rr_ptr) begin
          hi_ch    = CH_W'(c);
          hi_found = 1'b1;
        end
      end
    end
    next_ch = hi_found ? hi_ch : lo_ch;
  end

  // Trigger source is mode dependent; in single-shot mode the strobe is ignored entirely.
  assign any_enabled = |adc.channel_mask;
  assign trigger     = (state == S_IDLE) && any_enabled &&
                       (adc.mode ? adc.start : strobe);

  // Comparator decision for the bit under test, then the next trial with the following bit set.
  always_comb begin
    trial_kept = trial;
    if (adc.compare_match_n) begin
      trial_kept[bit_idx] = 1'b0;
    end
    trial_next = trial_kept;
    if (bit_idx != '0) begin
      trial_next[bit_idx - 1'b1] = 1'b1;
    end
  end

  // Conversion sequencer, channel pointer, result capture and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      trial   <= '0;
      rr_ptr  <= PTR_RESET;
      ch_sel  <= '0;
      res     <= '0;
      res_ch  <= '0;
      res_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      // Only continuous-mode strobes count as overrun; a start while busy is silently dropped.
      if (!adc.mode && strobe && (state != S_IDLE)) begin
        ovr <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (trigger) begin
            ch_sel <= next_ch;
            rr_ptr <= next_ch;
            timer  <= '0;
            state  <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (timer == SAMPLE_LAST) begin
            timer   <= '0;
            trial   <= TRIAL_MSB;
            bit_idx <= BIT_MSB;
            state   <= S_SETTLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= S_DECIDE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DECIDE: begin
          if (bit_idx == '0) begin
            // Result registers update here so they are already valid during the DONE cycle.
            trial   <= trial_kept;
            res     <= trial_kept;
            res_ch  <= ch_sel;
            res_vld <= 1'b1;
            state   <= S_DONE;
          end else begin
            trial   <= trial_next;
            bit_idx <= bit_idx - 1'b1;
            state   <= S_SETTLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The ladder sees the trial code only while it is being settled and compared; zero otherwise.
  assign adc.r2r_out        = ((state == S_SETTLE) || (state == S_DECIDE)) ? trial : '0;
  assign adc.sample_control = (state == S_SAMPLE);
  assign adc.busy           = (state != S_IDLE);
  assign adc.channel_sel    = ch_sel;
  assign adc.result         = res;
  assign adc.result_channel = res_ch;
  assign adc.result_valid   = res_vld;
  assign adc.overrun        = ovr;

endmodule

// File: tb/tb_r2r_sar_adc_multich.sv
// Directed bench for r2r_sar_adc_multich: single-shot, code extremes, masks, round-robin, overrun, reset.
// Latency: checks the 29-cycle default conversion schedule and 200-cycle continuous spacing.
// Backpressure: none; the comparator is modelled as compare_match_n = (r2r_out > vin).
module tb_r2r_sar_adc_multich;

  logic clk;
  logic reset;
  logic reset2;

  logic [7:0] vin [0:3];
  logic [7:0] vin2;
  logic [7:0] seq [0:7];

  int errors = 0;
  int checks = 0;

  r2r_sar_adc_multich_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  r2r_sar_adc_multich_if #(.WIDTH(8), .CHANNELS(4)) bus2 ();

  r2r_sar_adc_multich #(
    .WIDTH(8), .CHANNELS(4), .DIV(200), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .adc   (bus)
  );

  r2r_sar_adc_multich #(
    .WIDTH(8), .CHANNELS(4), .DIV(20), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)
  ) dut2 (
    .clk   (clk),
    .reset (reset2),
    .adc   (bus2)
  );

  // comparator models: low when the analog input exceeds the DAC code
  assign bus.compare_match_n  = (bus.r2r_out > vin[bus.channel_sel]);
  assign bus2.compare_match_n = (bus2.r2r_out > vin2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // waits until result_valid, counting cycles from n; n ends at limit on timeout
  task automatic wait_valid(input int limit, inout int n);
    while (!bus.result_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    int  pulses;
    logic busy_seen, valid_seen, ovr_seen, ovr_drop;

    seq[0] = 8'h80; seq[1] = 8'hC0; seq[2] = 8'hE0; seq[3] = 8'hF0;
    seq[4] = 8'hF8; seq[5] = 8'hFC; seq[6] = 8'hFE; seq[7] = 8'hFF;
    vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
    vin2 = 8'h5A;

    reset  = 1'b1;
    reset2 = 1'b1;
    bus.mode = 1'b1;
    bus.start = 1'b0;
    bus.channel_mask = 4'b0000;
    bus2.mode = 1'b0;
    bus2.start = 1'b0;
    bus2.channel_mask = 4'b0001;
    repeat (3) tick();

    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_sample_control", bus.sample_control, 0);
    chk("rst_channel_sel", bus.channel_sel, 0);
    chk("rst_r2r_out", bus.r2r_out, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_channel", bus.result_channel, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    tick();

    // single-shot on channel 0, vin=0xA5
    bus.channel_mask = 4'b0001;
    vin[0] = 8'hA5;
    pulse_start();
    n = 1;
    chk("t1_busy", bus.busy, 1);
    chk("t1_sample_control", bus.sample_control, 1);
    chk("t1_channel_sel", bus.channel_sel, 0);
    wait_valid(60, n);
    chk("t1_latency", n, 29);
    chk("t1_result", bus.result, 8'hA5);
    chk("t1_result_channel", bus.result_channel, 0);
    tick();
    chk("t1_valid_width", bus.result_valid, 0);
    chk("t1_idle_after", bus.busy, 0);
    chk("t1_result_held", bus.result, 8'hA5);

    // code extreme 0x00
    vin[0] = 8'h00;
    pulse_start();
    n = 1;
    wait_valid(60, n);
    chk("t2_latency", n, 29);
    chk("t2_result_zero", bus.result, 8'h00);
    tick();

    // code extreme 0xFF, with MSB-first trial sequence on the ladder
    vin[0] = 8'hFF;
    pulse_start();
    n = 1;
    while (!bus.result_valid && n < 60) begin
      if (n == 4) chk("t3_sampling", bus.sample_control, 1);
      if (n == 5) chk("t3_hold", bus.sample_control, 0);
      if (n >= 5 && n < 29 && ((n - 5) % 3) == 0)
        chk($sformatf("t3_r2r_bit%0d", (n - 5) / 3), bus.r2r_out, seq[(n - 5) / 3]);
      tick();
      n++;
    end
    chk("t3_latency", n, 29);
    chk("t3_result_full", bus.result, 8'hFF);
    tick();

    // start while busy is ignored
    vin[0] = 8'h5A;
    pulse_start();
    pulses = 0;
    for (int k = 2; k <= 70; k++) begin
      bus.start = (k == 11);
      tick();
      if (bus.result_valid) pulses++;
    end
    bus.start = 1'b0;
    chk("t5_single_result", pulses, 1);
    chk("t5_result", bus.result, 8'h5A);

    // empty mask: neither start nor strobe may launch a conversion
    bus.channel_mask = 4'b0000;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    ovr_seen = 1'b0;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      busy_seen |= bus.busy;
      valid_seen |= bus.result_valid;
      tick();
    end
    chk("t4_start_busy", busy_seen, 0);
    chk("t4_start_valid", valid_seen, 0);
    bus.mode = 1'b0;
    for (int k = 0; k < 210; k++) begin
      busy_seen |= bus.busy;
      valid_seen |= bus.result_valid;
      ovr_seen |= bus.overrun;
      tick();
    end
    chk("t4_strobe_busy", busy_seen, 0);
    chk("t4_strobe_valid", valid_seen, 0);
    chk("t4_overrun", ovr_seen, 0);

    // continuous round-robin over channels 1 and 3
    vin[1] = 8'h33;
    vin[3] = 8'hCC;
    bus.channel_mask = 4'b1010;
    n = 0;
    wait_valid(300, n);
    chk("t6_first_seen", (n < 300), 1);
    chk("t6_first_channel", bus.result_channel, 1);
    chk("t6_first_result", bus.result, 8'h33);
    n = 0;
    do begin tick(); n++; end while (!bus.result_valid && n < 400);
    chk("t6_spacing_1", n, 200);
    chk("t6_second_channel", bus.result_channel, 3);
    chk("t6_second_result", bus.result, 8'hCC);
    n = 0;
    do begin tick(); n++; end while (!bus.result_valid && n < 400);
    chk("t6_spacing_2", n, 200);
    chk("t6_third_channel", bus.result_channel, 1);
    chk("t6_third_result", bus.result, 8'h33);
    chk("t6_no_overrun", bus.overrun, 0);
    bus.mode = 1'b1;
    tick();

    // mid-conversion reset; pointer returns to its reset value
    bus.channel_mask = 4'b1111;
    vin[0] = 8'h1E;
    vin[2] = 8'h77;
    pulse_start();
    chk("t7_pick_after_ch1", bus.channel_sel, 2);
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    chk("t7_busy", bus.busy, 0);
    chk("t7_sample_control", bus.sample_control, 0);
    chk("t7_channel_sel", bus.channel_sel, 0);
    chk("t7_r2r_out", bus.r2r_out, 0);
    chk("t7_result", bus.result, 0);
    chk("t7_result_channel", bus.result_channel, 0);
    chk("t7_result_valid", bus.result_valid, 0);
    chk("t7_overrun", bus.overrun, 0);
    reset = 1'b0;
    valid_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      valid_seen |= bus.result_valid;
    end
    chk("t7_no_valid_after_abort", valid_seen, 0);
    pulse_start();
    chk("t7_lowest_channel", bus.channel_sel, 0);
    n = 1;
    wait_valid(60, n);
    chk("t7_latency", n, 29);
    chk("t7_result_after", bus.result, 8'h1E);
    chk("t7_channel_after", bus.result_channel, 0);

    // overrun with DIV=20 on the second instance
    reset2 = 1'b0;
    n = 0;
    while (!bus2.busy && n < 40) begin
      tick();
      n++;
    end
    chk("t8_started", (n < 40), 1);
    n = 1;
    pulses = 0;
    ovr_drop = 1'b0;
    while (n < 85) begin
      if (n == 20) chk("t8_overrun_before", bus2.overrun, 0);
      if (n == 21) chk("t8_overrun_set", bus2.overrun, 1);
      if (n == 29) begin
        chk("t8_first_valid", bus2.result_valid, 1);
        chk("t8_first_result", bus2.result, 8'h5A);
      end
      if (n > 21 && !bus2.overrun) ovr_drop = 1'b1;
      if (bus2.result_valid) pulses++;
      tick();
      n++;
    end
    chk("t8_overrun_sticky", ovr_drop, 0);
    chk("t8_conversions_complete", pulses, 2);
    chk("t8_busy_again", bus2.busy, 1);
    reset2 = 1'b1;
    tick();
    chk("t8_reset_overrun", bus2.overrun, 0);
    chk("t8_reset_result", bus2.result, 0);
    chk("t8_reset_busy", bus2.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
